// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: vending transaction sequencer.
// Latches the slot selection and checks stock on confirm. It runs the timed
// payment session and accumulates coins. It issues one commit per sale and
// reports change or refund.
// Optional feature macro: VEND_TXN_WARN_EN enables the timeout_warn window
// comparator. Without it, timeout_warn is tied low.
//
// Commit handshake: commit_valid rises on entry to COMMIT. It stays high, with
// commit_slot/commit_qty/commit_amount held stable, until the first clock edge
// at which commit_ready is sampled high. That edge transfers the sale, and
// commit_valid is low from the next cycle on.
module vend_txn_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000000,
  parameter logic [31:0] WARN_CYCLES    = 32'd500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_valid,
  input  logic [1:0]  sel_slot,
  input  logic        confirm,
  input  logic [1:0]  buy_qty,
  input  logic [11:0] prices,
  input  logic [5:0]  stock,
  input  logic        coin_valid,
  input  logic [1:0]  coin_val,
  input  logic        cancel,
  input  logic        admin_lock,
  input  logic        result_ack,
  output logic        commit_valid,
  input  logic        commit_ready,
  output logic [1:0]  commit_slot,
  output logic [1:0]  commit_qty,
  output logic [5:0]  commit_amount,
  output logic [5:0]  due,
  output logic [5:0]  paid,
  output logic [5:0]  change_out,
  output logic [2:0]  state_o,
  output logic        sold_out,
  output logic        timeout_warn
);

  // Parameter sanity; a payment window shorter than 2 cycles cannot time out cleanly.
  if (TIMEOUT_CYCLES < 32'd2) begin : g_bad_timeout
    $error("vend_txn_ctrl: TIMEOUT_CYCLES must be >= 2");
  end
  if (WARN_CYCLES > TIMEOUT_CYCLES) begin : g_bad_warn
    $error("vend_txn_ctrl: WARN_CYCLES must not exceed TIMEOUT_CYCLES");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECTED  = 3'd1,
    S_PAYING    = 3'd2,
    S_COMMIT    = 3'd3,
    S_DONE_OK   = 3'd4,
    S_DONE_FAIL = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [1:0]  qty_q, qty_d;
  logic [5:0]  due_q, due_d;
  logic [5:0]  paid_q, paid_d;
  logic [5:0]  change_q, change_d;
  logic [31:0] timer_q, timer_d;
  logic        sold_q, sold_d;
  logic        commit_q, commit_d;

  logic [3:0]  price_sel;
  logic [1:0]  stock_sel;
  logic [3:0]  coin_amt;
  logic [6:0]  paid_sum;
  logic [5:0]  paid_sat;
  logic [5:0]  due_calc;

  // Datapath helpers: slot lookup, coin value, saturating coin sum, due product.
  always_comb begin
    price_sel = 4'd0;
    stock_sel = 2'd0;
    case (slot_q)
      2'd1: begin price_sel = prices[3:0];  stock_sel = stock[1:0]; end
      2'd2: begin price_sel = prices[7:4];  stock_sel = stock[3:2]; end
      2'd3: begin price_sel = prices[11:8]; stock_sel = stock[5:4]; end
      default: ;
    endcase
    coin_amt = 4'd0;
    if (coin_valid) begin
      case (coin_val)
        2'b01:   coin_amt = 4'd1;
        2'b10:   coin_amt = 4'd5;
        2'b11:   coin_amt = 4'd10;
        default: coin_amt = 4'd0;
      endcase
    end
    paid_sum = {1'b0, paid_q} + {3'b000, coin_amt};
    paid_sat = paid_sum[6] ? 6'd63 : paid_sum[5:0];
    due_calc = {4'd0, buy_qty} * {2'd0, price_sel};
  end

  // Next-state and next-register values for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    qty_d    = qty_q;
    due_d    = due_q;
    paid_d   = paid_q;
    change_d = change_q;
    timer_d  = timer_q;
    sold_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_valid && (sel_slot != 2'd0) && !admin_lock) begin
          slot_d  = sel_slot;
          state_d = S_SELECTED;
        end
      end
      S_SELECTED: begin
        if (admin_lock) begin
          state_d = S_IDLE;
          slot_d  = 2'd0;
        end else if (sel_valid) begin
          slot_d = sel_slot;
          if (sel_slot == 2'd0) state_d = S_IDLE;
        end else if (confirm) begin
          if ((buy_qty == 2'd0) || (stock_sel < buy_qty)) begin
            sold_d = 1'b1;
          end else begin
            qty_d   = buy_qty;
            due_d   = due_calc;
            paid_d  = 6'd0;
            timer_d = 32'd0;
            state_d = S_PAYING;
          end
        end
      end
      S_PAYING: begin
        // A completing coin beats cancel, which beats timeout; a
        // non-completing coin in the same cycle is still refunded.
        paid_d  = paid_sat;
        timer_d = timer_q + 32'd1;
        if (paid_sat >= due_q) begin
          state_d = S_COMMIT;
        end else if (cancel || (timer_q == TIMEOUT_CYCLES - 32'd1)) begin
          change_d = paid_sat;
          state_d  = S_DONE_FAIL;
        end
      end
      S_COMMIT: begin
        if (commit_ready) begin
          change_d = paid_q - due_q;
          state_d  = S_DONE_OK;
        end
      end
      S_DONE_OK, S_DONE_FAIL: begin
        if (result_ack) begin
          slot_d   = 2'd0;
          qty_d    = 2'd0;
          due_d    = 6'd0;
          paid_d   = 6'd0;
          change_d = 6'd0;
          timer_d  = 32'd0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    commit_d = (state_d == S_COMMIT);
  end

  // State and datapath registers; reset discards any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      slot_q   <= 2'd0;
      qty_q    <= 2'd0;
      due_q    <= 6'd0;
      paid_q   <= 6'd0;
      change_q <= 6'd0;
      timer_q  <= 32'd0;
      sold_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      qty_q    <= qty_d;
      due_q    <= due_d;
      paid_q   <= paid_d;
      change_q <= change_d;
      timer_q  <= timer_d;
      sold_q   <= sold_d;
      commit_q <= commit_d;
    end
  end

`ifdef VEND_TXN_WARN_EN
  logic warn_q;
  // Warn register: high while paying within WARN_CYCLES of expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) warn_q <= 1'b0;
    else      warn_q <= (state_d == S_PAYING) &&
                        ((TIMEOUT_CYCLES - timer_d) <= WARN_CYCLES);
  end
  assign timeout_warn = warn_q;
`else
  assign timeout_warn = 1'b0;
`endif

  assign commit_valid  = commit_q;
  assign commit_slot   = slot_q;
  assign commit_qty    = qty_q;
  assign commit_amount = due_q;
  assign due           = due_q;
  assign paid          = paid_q;
  assign change_out    = change_q;
  assign state_o       = state_q;
  assign sold_out      = sold_q;

endmodule
